lcd_byte_writer: RTL



---
 rtl/lcd_byte_writer_if.sv | 12 +
 rtl/lcd_byte_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer_if.sv
// Core-side write handshake for the HD44780 byte writer.
// The core (master) offers a byte; the writer (slave) reports busy and init status.
interface lcd_byte_writer_if;
  logic       iWrite;
  logic       iRS;
  logic [7:0] iData;
  logic       oBusy;
  logic       oInitDone;

  modport master (output iWrite, iRS, iData, input  oBusy, oInitDone);
  modport slave  (input  iWrite, iRS, iData, output oBusy, oInitDone);
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit bus writer: autonomous power-on init and configuration, then
// splits each accepted byte into two E-strobed nibbles with all LCD waits enforced.
module lcd_byte_writer #(
  parameter int T_POWERON = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_NIBBLE  = 50,
  parameter int CW        = 20
) (
  input  logic             Clock,
  input  logic             Reset,
  lcd_byte_writer_if.slave bus,
  output logic             oLCD_E,
  output logic             oLCD_RS,
  output logic             oLCD_RW,
  output logic [3:0]       oLCD_Data,
  output logic             oLCD_StrataFlashControl
);

  typedef logic [CW-1:0] cnt_t;

  // Terminal counts: a state with duration T exits when the counter reaches T-1.
  localparam cnt_t L_POWERON = cnt_t'(T_POWERON - 1);
  localparam cnt_t L_INIT1   = cnt_t'(T_INIT1 - 1);
  localparam cnt_t L_INIT2   = cnt_t'(T_INIT2 - 1);
  localparam cnt_t L_CMD     = cnt_t'(T_CMD - 1);
  localparam cnt_t L_CLEAR   = cnt_t'(T_CLEAR - 1);
  localparam cnt_t L_SETUP   = cnt_t'(T_SETUP - 1);
  localparam cnt_t L_EHIGH   = cnt_t'(T_EHIGH - 1);
  localparam cnt_t L_NIBBLE  = cnt_t'(T_NIBBLE - 1);
  localparam cnt_t L_NIB_END = cnt_t'(T_SETUP + T_EHIGH - 1);
  localparam cnt_t C_ZERO    = cnt_t'(0);
  localparam cnt_t C_ONE     = cnt_t'(1);

  typedef enum logic [3:0] {
    S_POWERON   = 4'd0,
    S_INIT_NIB  = 4'd1,
    S_INIT_WAIT = 4'd2,
    S_CFG       = 4'd3,
    S_IDLE      = 4'd4,
    S_HI_SETUP  = 4'd5,
    S_HI_E      = 4'd6,
    S_HI_GAP    = 4'd7,
    S_LO_SETUP  = 4'd8,
    S_LO_E      = 4'd9,
    S_POST_WAIT = 4'd10
  } state_t;

  state_t     r_state;
  cnt_t       r_cnt;
  logic [1:0] r_init_idx;
  logic [1:0] r_cfg_idx;
  logic       r_cfg_mode;
  logic [7:0] r_byte;
  logic       r_rs;
  logic       r_e;
  logic       r_lcd_rs;
  logic [3:0] r_lcd_data;
  logic       r_busy;
  logic       r_init_done;

  cnt_t       w_init_wait;
  cnt_t       w_post_wait;
  logic [7:0] w_cfg_byte;
  logic [3:0] w_next_nib;

  // Per-step lookups: init waits, post-byte wait, configuration command table.
  always_comb begin
    w_init_wait = L_CMD;
    w_post_wait = L_CMD;
    w_cfg_byte  = 8'h01;
    w_next_nib  = 4'h3;
    case (r_init_idx)
      2'd0:    w_init_wait = L_INIT1;
      2'd1:    w_init_wait = L_INIT2;
      default: w_init_wait = L_CMD;
    endcase
    if (!r_rs && (r_byte == 8'h01 || r_byte == 8'h02)) begin
      w_post_wait = L_CLEAR;
    end else begin
      w_post_wait = L_CMD;
    end
    case (r_cfg_idx)
      2'd0:    w_cfg_byte = 8'h28;
      2'd1:    w_cfg_byte = 8'h06;
      2'd2:    w_cfg_byte = 8'h0C;
      default: w_cfg_byte = 8'h01;
    endcase
    if (r_init_idx == 2'd2) begin
      w_next_nib = 4'h2;
    end else begin
      w_next_nib = 4'h3;
    end
  end

  // Main sequencer; every output is registered alongside the state change.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_POWERON;
      r_cnt       <= C_ZERO;
      r_init_idx  <= 2'd0;
      r_cfg_idx   <= 2'd0;
      r_cfg_mode  <= 1'b0;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 4'h0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_cnt <= r_cnt + C_ONE;
      case (r_state)
        S_POWERON: if (r_cnt == L_POWERON) begin
          r_state    <= S_INIT_NIB;
          r_cnt      <= C_ZERO;
          r_lcd_rs   <= 1'b0;
          r_lcd_data <= 4'h3;
        end
        S_INIT_NIB: if (r_cnt == L_SETUP) begin
          r_e <= 1'b1;
        end else if (r_cnt == L_NIB_END) begin
          r_e     <= 1'b0;
          r_state <= S_INIT_WAIT;
          r_cnt   <= C_ZERO;
        end
        S_INIT_WAIT: if (r_cnt == w_init_wait) begin
          r_cnt <= C_ZERO;
          if (r_init_idx == 2'd3) begin
            r_state    <= S_CFG;
            r_cfg_mode <= 1'b1;
            r_cfg_idx  <= 2'd0;
          end else begin
            r_init_idx <= r_init_idx + 2'd1;
            r_lcd_data <= w_next_nib;
            r_state    <= S_INIT_NIB;
          end
        end
        S_CFG: begin
          r_byte     <= w_cfg_byte;
          r_rs       <= 1'b0;
          r_lcd_rs   <= 1'b0;
          r_lcd_data <= w_cfg_byte[7:4];
          r_state    <= S_HI_SETUP;
          r_cnt      <= C_ZERO;
        end
        // The counter is parked here so it never runs free between writes.
        S_IDLE: begin
          r_cnt <= C_ZERO;
          if (bus.iWrite) begin
            r_byte     <= bus.iData;
            r_rs       <= bus.iRS;
            r_lcd_rs   <= bus.iRS;
            r_lcd_data <= bus.iData[7:4];
            r_busy     <= 1'b1;
            r_state    <= S_HI_SETUP;
          end
        end
        S_HI_SETUP: if (r_cnt == L_SETUP) begin
          r_e     <= 1'b1;
          r_state <= S_HI_E;
          r_cnt   <= C_ZERO;
        end
        S_HI_E: if (r_cnt == L_EHIGH) begin
          r_e     <= 1'b0;
          r_state <= S_HI_GAP;
          r_cnt   <= C_ZERO;
        end
        S_HI_GAP: if (r_cnt == L_NIBBLE) begin
          r_lcd_data <= r_byte[3:0];
          r_state    <= S_LO_SETUP;
          r_cnt      <= C_ZERO;
        end
        S_LO_SETUP: if (r_cnt == L_SETUP) begin
          r_e     <= 1'b1;
          r_state <= S_LO_E;
          r_cnt   <= C_ZERO;
        end
        S_LO_E: if (r_cnt == L_EHIGH) begin
          r_e     <= 1'b0;
          r_state <= S_POST_WAIT;
          r_cnt   <= C_ZERO;
        end
        S_POST_WAIT: if (r_cnt == w_post_wait) begin
          r_cnt <= C_ZERO;
          if (r_cfg_mode && r_cfg_idx != 2'd3) begin
            r_cfg_idx <= r_cfg_idx + 2'd1;
            r_state   <= S_CFG;
          end else begin
            r_cfg_mode  <= 1'b0;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_POWERON;
          r_cnt   <= C_ZERO;
          r_e     <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign oLCD_E                  = r_e;
  assign oLCD_RS                 = r_lcd_rs;
  assign oLCD_Data               = r_lcd_data;
  assign oLCD_RW                 = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;
  assign bus.oBusy               = r_busy;
  assign bus.oInitDone           = r_init_done;

endmodule
